// File: rtl/smg_scan_mux_if.sv
// Display-data and pin bundle for the multiplexed seven-segment driver.
interface smg_scan_mux_if #(
   parameter int DIGITS = 6
);
   logic [4*DIGITS-1:0] Digit_Data;
   logic [DIGITS-1:0]   Dp_Mask;
   logic [DIGITS-1:0]   En_Mask;
   logic [DIGITS-1:0]   Scan_Sig;
   logic [7:0]          Seg_Sig;
   logic                Frame_Done;

   modport master (
      output Digit_Data, Dp_Mask, En_Mask,
      input  Scan_Sig, Seg_Sig, Frame_Done
   );

   modport slave (
      input  Digit_Data, Dp_Mask, En_Mask,
      output Scan_Sig, Seg_Sig, Frame_Done
   );
endinterface

// File: rtl/smg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-slot blanking,
// per-digit enable/dp masks and configurable pin polarity.
module smg_scan_mux #(
   parameter int          DIGITS         = 6,
   parameter logic [15:0] TICK_MAX       = 16'd49999,
   parameter int          BLANK_CYC      = 500,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input logic            CLK,
   input logic            RSTn,
   smg_scan_mux_if.slave  bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [15:0]       c1_r;
   logic [IDX_W-1:0]  idx_r;
   logic [DIGITS-1:0] scan_r;
   logic [7:0]        seg_r;
   logic              frame_done_r;

   logic              slot_end_s;
   logic              blank_s;
   logic              drive_s;
   logic [3:0]        nib_s;
   logic              dp_s;
   logic              en_s;
   logic [DIGITS-1:0] sel_hit_s;
   logic [DIGITS-1:0] sel_s;
   logic [7:0]        seg_s;

   // Active-high gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         4'hF:    s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign slot_end_s = (c1_r == TICK_MAX);
   // 17-bit compare so BLANK_CYC = TICK_MAX+1 (up to 65536) keeps the slot dark.
   assign blank_s    = ({1'b0, c1_r} < 17'(BLANK_CYC));

   // Slot counter and digit index.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         c1_r  <= 16'd0;
         idx_r <= '0;
      end else if (slot_end_s) begin
         c1_r  <= 16'd0;
         idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
      end else begin
         c1_r  <= c1_r + 16'd1;
         idx_r <= idx_r;
      end
   end

   // Select the current digit's data, masks and one-hot select (digit 0 = MSB).
   always_comb begin
      nib_s     = 4'h0;
      dp_s      = 1'b0;
      en_s      = 1'b0;
      sel_hit_s = '0;
      for (int k = 0; k < DIGITS; k++) begin
         nib_s               = nib_s | (bus.Digit_Data[4*k +: 4] & {4{idx_r == IDX_W'(k)}});
         dp_s                = dp_s  | (bus.Dp_Mask[k] & (idx_r == IDX_W'(k)));
         en_s                = en_s  | (bus.En_Mask[k] & (idx_r == IDX_W'(k)));
         sel_hit_s[DIGITS-1-k] = (idx_r == IDX_W'(k));
      end
      drive_s = !blank_s && en_s;
      sel_s   = drive_s ? sel_hit_s : '0;
      seg_s   = drive_s ? {dp_s, hex_to_seg(nib_s)} : 8'h00;
   end

   // Output registers; pin polarity is applied only here.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         scan_r       <= {DIGITS{SEL_ACTIVE_LOW}};
         seg_r        <= {8{SEG_ACTIVE_LOW}};
         frame_done_r <= 1'b0;
      end else begin
         scan_r       <= sel_s ^ {DIGITS{SEL_ACTIVE_LOW}};
         seg_r        <= seg_s ^ {8{SEG_ACTIVE_LOW}};
         frame_done_r <= slot_end_s && (idx_r == IDX_W'(DIGITS - 1));
      end
   end

   assign bus.Scan_Sig   = scan_r;
   assign bus.Seg_Sig    = seg_r;
   assign bus.Frame_Done = frame_done_r;
endmodule

// File: tb/tb_smg_scan_mux.sv
// Scoreboard bench: three smg_scan_mux configurations share clock and reset;
// expectations are queued per output cycle and checked by a negedge monitor.
module tb_smg_scan_mux;
   logic CLK;
   logic RSTn;

   smg_scan_mux_if #(.DIGITS(6)) bus_m ();
   smg_scan_mux_if #(.DIGITS(4)) bus_a ();
   smg_scan_mux_if #(.DIGITS(6)) bus_d ();

   smg_scan_mux #(.DIGITS(6), .TICK_MAX(16'd9), .BLANK_CYC(2),
                  .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
      u_main (.CLK(CLK), .RSTn(RSTn), .bus(bus_m));

   smg_scan_mux #(.DIGITS(4), .TICK_MAX(16'd9), .BLANK_CYC(0),
                  .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0))
      u_alt (.CLK(CLK), .RSTn(RSTn), .bus(bus_a));

   smg_scan_mux #(.DIGITS(6), .TICK_MAX(16'd9), .BLANK_CYC(10),
                  .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
      u_dark (.CLK(CLK), .RSTn(RSTn), .bus(bus_d));

   typedef struct {
      int         id;
      int         p;
      logic [7:0] scan;
      logic [7:0] seg;
      logic       fd;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   p        = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [6:0] seg_tab(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Queue expected outputs of all three instances for output cycle p (0 = in reset).
   task automatic push_all();
      exp_t e;
      int   qq, c, d;
      logic [5:0] one6;
      logic [3:0] one4;
      qq = p - 1;
      c  = qq % 10;
      // main: 6 digits, blank 2, active-low
      e.id = 0; e.p = p; e.scan = 8'h3F; e.seg = 8'hFF; e.fd = 1'b0;
      if (p > 0) begin
         d = (qq / 10) % 6;
         e.fd = (p % 60 == 0);
         if (c >= 2 && bus_m.En_Mask[d]) begin
            one6   = 6'b100000 >> d;
            e.scan = {2'b00, ~one6};
            e.seg  = ~{bus_m.Dp_Mask[d], seg_tab(bus_m.Digit_Data[4*d +: 4])};
         end
      end
      q.push_back(e);
      // alt: 4 digits, no blanking, active-high
      e.id = 1; e.scan = 8'h00; e.seg = 8'h00; e.fd = 1'b0;
      if (p > 0) begin
         d      = (qq / 10) % 4;
         one4   = 4'b1000 >> d;
         e.scan = {4'h0, one4};
         e.seg  = {bus_a.Dp_Mask[d], seg_tab(bus_a.Digit_Data[4*d +: 4])};
         e.fd   = (p % 40 == 0);
      end
      q.push_back(e);
      // dark: blank covers the whole slot
      e.id = 2; e.scan = 8'h3F; e.seg = 8'hFF; e.fd = (p > 0) && (p % 60 == 0);
      q.push_back(e);
   endtask

   // One clock: count the edge if RSTn was high at it, then apply new RSTn, then queue.
   task automatic cyc(input logic rst_val);
      @(posedge CLK);
      #1;
      if (RSTn) p++;
      RSTn = rst_val;
      if (!RSTn) p = 0;
      push_all();
   endtask

   // Monitor: compare every queued expectation against the live outputs.
   always @(negedge CLK) begin
      exp_t       e;
      logic [7:0] a_scan, a_seg;
      logic       a_fd;
      string      nm;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.id)
            0: begin a_scan = {2'b00, bus_m.Scan_Sig}; a_seg = bus_m.Seg_Sig; a_fd = bus_m.Frame_Done; nm = "main"; end
            1: begin a_scan = {4'h0, bus_a.Scan_Sig};  a_seg = bus_a.Seg_Sig; a_fd = bus_a.Frame_Done; nm = "alt";  end
            default: begin a_scan = {2'b00, bus_d.Scan_Sig}; a_seg = bus_d.Seg_Sig; a_fd = bus_d.Frame_Done; nm = "dark"; end
         endcase
         n_checks++;
         if (a_scan !== e.scan || a_seg !== e.seg || a_fd !== e.fd) begin
            n_fail++;
            $display("FAIL %s p=%0d: got scan=%h seg=%h fd=%b, expected scan=%h seg=%h fd=%b",
                     nm, e.p, a_scan, a_seg, a_fd, e.scan, e.seg, e.fd);
         end
      end
   end

   initial begin
      RSTn = 1'b0;
      bus_m.Digit_Data = 24'h543210; bus_m.En_Mask = 6'h3F; bus_m.Dp_Mask = 6'h00;
      bus_d.Digit_Data = 24'h543210; bus_d.En_Mask = 6'h3F; bus_d.Dp_Mask = 6'h3F;
      bus_a.Digit_Data = 16'h9A5C;   bus_a.En_Mask = 4'hF;  bus_a.Dp_Mask = 4'b0101;

      // Reset, release, two full frames of the basic pattern
      repeat (3) cyc(1'b0);
      cyc(1'b1);
      repeat (125) cyc(1'b1);

      // Sweep all hex values through digit 0 with its dp lit
      bus_m.Dp_Mask = 6'b000001;
      for (int v = 0; v < 16; v++) begin
         bus_m.Digit_Data[3:0] = 4'(v);
         repeat (60) cyc(1'b1);
      end
      bus_m.Digit_Data = 24'h543210;
      bus_m.Dp_Mask    = 6'h00;

      // Digit 0 disabled
      bus_m.En_Mask = 6'b111110;
      repeat (120) cyc(1'b1);
      bus_m.En_Mask = 6'h3F;

      // Asynchronous reset at cycle 5 of digit 3's slot, then restart from digit 0
      while (p % 60 != 35) cyc(1'b1);
      cyc(1'b0);
      repeat (3) cyc(1'b0);
      cyc(1'b1);
      repeat (130) cyc(1'b1);

      @(negedge CLK);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
